// File: rtl/risc_pipe_core.sv
// 3-stage pipelined RISC core (Issue, Read, Execute/Writeback) with ALU-to-Read bypass.
// Optional macro RISC_ILLEGAL_TRAP_EN: opcodes C-F raise a sticky illegal_op and stop issue.
module risc_pipe_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] operand_1,
    input  logic [IMM_W-1:0]  operand_2,
    input  logic              cin,
    output logic [DATA_W-1:0] alu_op,
    output logic              cb,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              illegal_op
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_ADC = 4'h3,
        OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_SHL = 4'h8, OP_SHR = 4'h9, OP_MOV = 4'hA, OP_RD  = 4'hB
    } op_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_vld, rd_cin;
    logic [3:0]        rd_op;
    logic [ADDR_W-1:0] rd_dst;
    logic [IMM_W-1:0]  rd_imm;

    logic              ex_vld, ex_cin;
    logic [3:0]        ex_op;
    logic [ADDR_W-1:0] ex_dst;
    logic [DATA_W-1:0] ex_s, ex_a;

    logic              adv;
    logic [ADDR_W-1:0] src;
    logic [DATA_W-1:0] rd_val, res;
    logic              cout, ex_writes, ex_produces;

    assign adv = !result_valid || result_ready;

`ifdef RISC_ILLEGAL_TRAP_EN
    assign instr_ready = adv && !illegal_op;
`else
    assign instr_ready = adv;
    assign illegal_op  = 1'b0;
`endif

    // MOV sources from the immediate; everything else reads its own destination
    assign src    = (rd_op == OP_MOV) ? rd_imm[ADDR_W-1:0] : rd_dst;
    assign rd_val = (ex_vld && ex_writes && ex_dst == src) ? res : mem[src];

    assign ex_writes   = (ex_op >= OP_LDI) && (ex_op <= OP_MOV);
    assign ex_produces = (ex_op >= OP_LDI) && (ex_op <= OP_RD);

    always_comb begin
        res  = ex_a;
        cout = cb;
        case (ex_op)
            OP_LDI: res = ex_s;
            OP_ADD: {cout, res} = {1'b0, ex_a} + {1'b0, ex_s};
            OP_ADC: {cout, res} = {1'b0, ex_a} + {1'b0, ex_s} + (DATA_W+1)'(ex_cin);
            OP_SUB: {cout, res} = {1'b0, ex_a} - {1'b0, ex_s};
            OP_AND: res = ex_a & ex_s;
            OP_OR:  res = ex_a | ex_s;
            OP_XOR: res = ex_a ^ ex_s;
            OP_SHL: begin res = ex_a << 1; cout = ex_a[DATA_W-1]; end
            OP_SHR: begin res = ex_a >> 1; cout = ex_a[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld       <= 1'b0;
            rd_cin       <= 1'b0;
            rd_op        <= '0;
            rd_dst       <= '0;
            rd_imm       <= '0;
            ex_vld       <= 1'b0;
            ex_cin       <= 1'b0;
            ex_op        <= '0;
            ex_dst       <= '0;
            ex_s         <= '0;
            ex_a         <= '0;
            alu_op       <= '0;
            cb           <= 1'b0;
            result_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef RISC_ILLEGAL_TRAP_EN
            illegal_op   <= 1'b0;
`endif
        end else if (adv) begin
            rd_vld <= instr_valid && instr_ready;
            rd_op  <= opcode;
            rd_dst <= operand_1;
            rd_imm <= operand_2;
            rd_cin <= cin;
            ex_vld <= rd_vld;
            ex_op  <= rd_op;
            ex_dst <= rd_dst;
            ex_s   <= DATA_W'($signed(rd_imm));
            ex_cin <= rd_cin;
            ex_a   <= rd_val;
            result_valid <= ex_vld && ex_produces;
            if (ex_vld && ex_produces) begin
                alu_op <= res;
                cb     <= cout;
            end
            if (ex_vld && ex_writes) mem[ex_dst] <= res;
`ifdef RISC_ILLEGAL_TRAP_EN
            // the trap kills everything issued behind the illegal op
            if (ex_vld && ex_op >= 4'hC) begin
                illegal_op <= 1'b1;
                rd_vld     <= 1'b0;
                ex_vld     <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_risc_pipe_core.sv
// Scoreboard bench for risc_pipe_core: a sequential reference model pushes expected
// {cb, alu_op} at accept time; a negedge monitor pops on every result handshake.
module tb_risc_pipe_core;
    logic        clk = 0, rst = 1;
    logic        instr_valid = 0, instr_ready;
    logic [3:0]  opcode = 0;
    logic [3:0]  operand_1 = 0;
    logic [7:0]  operand_2 = 0;
    logic        cin = 0;
    logic [15:0] alu_op;
    logic        cb, result_valid, illegal_op;
    logic        result_ready = 1;

    int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    logic [16:0] sb[$];
    logic [15:0] mm [16];
    logic        cb_m = 0, trapped = 0;

    risc_pipe_core dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand_1(operand_1), .operand_2(operand_2), .cin(cin),
        .alu_op(alu_op), .cb(cb), .result_valid(result_valid),
        .result_ready(result_ready), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model, applied in program order at accept time
    task automatic model(input logic [3:0] op, input logic [3:0] a, input logic [7:0] imm,
                         input logic c);
        logic [15:0] s, va, r;
        logic [16:0] w;
        logic        nc, wr;
        s  = {{8{imm[7]}}, imm};
        va = mm[a];
        r  = va;
        nc = cb_m;
        wr = 1;
        if (trapped) return;
        case (op)
            4'h1: r = s;
            4'h2: begin w = va + s; r = w[15:0]; nc = w[16]; end
            4'h3: begin w = va + s + c; r = w[15:0]; nc = w[16]; end
            4'h4: begin r = va - s; nc = (va < s); end
            4'h5: r = va & s;
            4'h6: r = va | s;
            4'h7: r = va ^ s;
            4'h8: begin r = {va[14:0], 1'b0}; nc = va[15]; end
            4'h9: begin r = {1'b0, va[15:1]}; nc = va[0]; end
            4'hA: r = mm[imm[3:0]];
            4'hB: wr = 0;
            default: begin
`ifdef RISC_ILLEGAL_TRAP_EN
                if (op >= 4'hC) trapped = 1;
`endif
                return;
            end
        endcase
        if (wr) mm[a] = r;
        cb_m = nc;
        sb.push_back({nc, r});
    endtask

    // Called #1 after a posedge; returns #1 after the accepting posedge
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [7:0] imm,
                         input logic c = 0);
        int n = 0;
        opcode = op; operand_1 = a; operand_2 = imm; cin = c; instr_valid = 1;
        forever begin
            @(negedge clk);
            if (instr_ready) break;
            if (++n > 50) begin
                chk("issue_timeout", 0, 1);
                instr_valid = 0;
                @(posedge clk); #1;
                return;
            end
        end
        model(op, a, imm, c);
        @(posedge clk); #1;
        acc_cyc = cyc;
        instr_valid = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            if (sb.size() == 0) chk("extra_result", result_valid, 0);
            else chk("result", {cb, alu_op}, sb.pop_front());
        end
    end

    initial begin
        int c0;
        logic [15:0] held;
        foreach (mm[i]) mm[i] = 0;
        #12;
        chk("rst_alu_op", alu_op, 0);
        chk("rst_cb", cb, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_illegal", illegal_op, 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        issue(4'h1, 3, 8'h85);
        issue(4'hB, 3, 8'h00);

        // back-to-back with bypass; accepts must land on consecutive cycles
        issue(4'h1, 1, 8'h7F); c0 = acc_cyc;
        issue(4'h2, 1, 8'h01);
        issue(4'h2, 1, 8'h01);
        chk("no_stall", acc_cyc - c0, 2);

        issue(4'h1, 2, 8'hFF);
        issue(4'h3, 2, 8'h00, 1);
        issue(4'h4, 2, 8'h01);
        issue(4'h5, 2, 8'h0F);

        issue(4'h1, 4, 8'h81);
        issue(4'h8, 4, 8'h00);
        issue(4'h9, 4, 8'h00);
        issue(4'h7, 4, 8'h0F);
        issue(4'h6, 4, 8'h70);
        issue(4'hA, 8, 8'h04);
        issue(4'h0, 8, 8'h00);
        issue(4'hB, 8, 8'h00);

        // backpressure: hold result_ready low for 3 cycles while streaming
        repeat (3) @(posedge clk); #1;
        result_ready = 0;
        fork
            begin
                issue(4'h1, 5, 8'h10);
                repeat (4) issue(4'h2, 5, 8'h01);
            end
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!result_valid && n < 20);
                held = alu_op;
                chk("hold_value", held, 16'h0010);
                repeat (3) begin
                    @(negedge clk);
                    chk("hold_ready", instr_ready, 0);
                    chk("hold_alu", alu_op, held);
                end
                @(posedge clk); #1 result_ready = 1;
            end
        join
        issue(4'hB, 5, 8'h00);

        // reset with two instructions in flight
        issue(4'h1, 6, 8'h33);
        issue(4'h1, 7, 8'h44);
        rst = 1;
        #1;
        chk("mid_rst_alu", alu_op, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_cb", cb, 0);
        sb.delete();
        foreach (mm[i]) mm[i] = 0;
        cb_m = 0;
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        issue(4'hB, 6, 8'h00);
        issue(4'hB, 7, 8'h00);

        issue(4'h1, 9, 8'h11);
        issue(4'hD, 9, 8'h00);
        issue(4'h1, 10, 8'h22);
`ifdef RISC_ILLEGAL_TRAP_EN
        repeat (4) @(posedge clk); #1;
        chk("trap_flag", illegal_op, 1);
        chk("trap_ready", instr_ready, 0);
`else
        issue(4'hB, 10, 8'h00);
        chk("no_trap_flag", illegal_op, 0);
`endif
        repeat (10) @(posedge clk);
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
